// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: game-phase FSM, move-tick divider and bounce/score decisions for the ball datapath.
// Every output is registered; tick decisions taken in cycle T appear together in T+1.
module ball_motion_ctrl #(
   parameter int BASE_DIV    = 800_000,
   parameter int DIV_STEP    = 100_000,
   parameter int MAX_LEVEL   = 4,
   parameter int SERVE_TICKS = 60,
   parameter int Y_MIN       = 10,
   parameter int Y_MAX       = 757,
   parameter int X_MIN       = 10,
   parameter int X_MAX       = 1013
) (
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        collision_det,
   input  logic [11:0] x_pos,
   input  logic [11:0] y_pos,
   output logic        step_en,
   output logic        dir_x,
   output logic        dir_y,
   output logic        load,
   output logic [2:0]  speed_level,
   output logic        score_left,
   output logic        score_right,
   output logic [1:0]  phase
);
   localparam logic [1:0] IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, SCORED = 2'd3;
   localparam logic [31:0] BASE_RELOAD = 32'(BASE_DIV - 1);
   logic [31:0] div;
   logic        latch;
   logic [1:0]  lockout;
   logic [15:0] serve_cnt;
   logic        tick, y_flip;
   logic [2:0]  lvl_nxt;
   logic [31:0] play_reload;
   always_comb begin
      tick        = (phase == SERVE || phase == PLAY) && div == 32'd0;
      lvl_nxt     = latch && speed_level != 3'(MAX_LEVEL) ? speed_level + 3'd1 : speed_level;
      y_flip      = dir_y ? y_pos >= 12'(Y_MAX) : y_pos <= 12'(Y_MIN);
      play_reload = BASE_RELOAD - 32'(DIV_STEP) * 32'(lvl_nxt);
   end
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         phase <= IDLE;
         step_en <= 1'b0;
         load <= 1'b0;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
         speed_level <= 3'd0;
         score_left <= 1'b0;
         score_right <= 1'b0;
         div <= BASE_RELOAD;
         latch <= 1'b0;
         lockout <= 2'd0;
         serve_cnt <= 16'd0;
      end else begin
         step_en <= 1'b0;
         load <= 1'b0;
         score_left <= 1'b0;
         score_right <= 1'b0;
         if (stop) begin
            phase <= IDLE;
            div <= BASE_RELOAD;
            latch <= 1'b0;
            lockout <= 2'd0;
            serve_cnt <= 16'd0;
         end else begin
            case (phase)
               IDLE: begin
                  div <= BASE_RELOAD;
                  if (start) begin
                     phase <= SERVE;
                     load <= 1'b1;
                     dir_x <= 1'b1;
                     dir_y <= 1'b1;
                     speed_level <= 3'd0;
                  end
               end
               SERVE: begin
                  div <= tick ? BASE_RELOAD : div - 32'd1;
                  if (tick) begin
                     serve_cnt <= serve_cnt == 16'(SERVE_TICKS - 1) ? 16'd0 : serve_cnt + 16'd1;
                     if (serve_cnt == 16'(SERVE_TICKS - 1))
                        phase <= PLAY;
                  end
               end
               PLAY: begin
                  if (tick) begin
                     latch <= 1'b0;
                     div <= play_reload;
                     lockout <= latch ? 2'd2 : (lockout != 2'd0 ? lockout - 2'd1 : 2'd0);
                     // a latched paddle hit outranks a goal-line crossing on the same tick
                     if (latch) begin
                        dir_x <= ~dir_x;
                        speed_level <= lvl_nxt;
                        step_en <= 1'b1;
                        dir_y <= dir_y ^ y_flip;
                     end else if (x_pos <= 12'(X_MIN)) begin
                        score_right <= 1'b1;
                        phase <= SCORED;
                        div <= BASE_RELOAD;
                     end else if (x_pos >= 12'(X_MAX)) begin
                        score_left <= 1'b1;
                        phase <= SCORED;
                        div <= BASE_RELOAD;
                     end else begin
                        step_en <= 1'b1;
                        dir_y <= dir_y ^ y_flip;
                     end
                  end else begin
                     div <= div - 32'd1;
                     if (collision_det && lockout == 2'd0)
                        latch <= 1'b1;
                  end
               end
               default: begin
                  // score_* still holds the pulse here, so it tells which side conceded
                  phase <= SERVE;
                  load <= 1'b1;
                  speed_level <= 3'd0;
                  latch <= 1'b0;
                  lockout <= 2'd0;
                  dir_y <= 1'b1;
                  dir_x <= score_left;
                  div <= BASE_RELOAD;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: table rows, directed corner sequences and random traffic checked against an
// absolute-time reference model of the ball scheduler.
module tb_ball_motion_ctrl;
   localparam int BD = 10, DS = 2, ML = 3, ST = 2, XMIN = 10, XMAX = 100, YMIN = 10, YMAX = 50;
   logic pclk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, collision_det = 1'b0;
   logic [11:0] x_pos = 12'd50, y_pos = 12'd30;
   logic step_en, dir_x, dir_y, load, score_left, score_right;
   logic [2:0] speed_level;
   logic [1:0] phase;
   ball_motion_ctrl #(.BASE_DIV(BD), .DIV_STEP(DS), .MAX_LEVEL(ML), .SERVE_TICKS(ST),
      .Y_MIN(YMIN), .Y_MAX(YMAX), .X_MIN(XMIN), .X_MAX(XMAX)) dut (
      .pclk(pclk), .reset_n(reset_n), .start(start), .stop(stop), .collision_det(collision_det),
      .x_pos(x_pos), .y_pos(y_pos), .step_en(step_en), .dir_x(dir_x), .dir_y(dir_y), .load(load),
      .speed_level(speed_level), .score_left(score_left), .score_right(score_right), .phase(phase));
   always #5 pclk = ~pclk;
   int errors = 0, checks = 0;
   // model: ticks are scheduled as absolute edge numbers rather than a counted-down divider
   int n, next_tick, serve_left, lock, m_phase, m_lvl;
   bit pend_hit, m_step, m_dx, m_dy, m_load, m_sl, m_sr;
   typedef struct {
      bit start, stop, col;
      int x, y, cycles, ph, lvl, dx;
   } row_t;
   row_t tbl[10];
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      end
   endtask
   task automatic model_reset();
      m_phase = 0; m_lvl = 0; m_dx = 1; m_dy = 1;
      m_step = 0; m_load = 0; m_sl = 0; m_sr = 0;
      pend_hit = 0; lock = 0; serve_left = 0; next_tick = 0; n = 0;
   endtask
   task automatic model_edge();
      bit was_left;
      bit yb;
      was_left = m_sl;
      n++;
      m_step = 0; m_load = 0; m_sl = 0; m_sr = 0;
      if (stop) begin
         m_phase = 0; pend_hit = 0; lock = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1; m_load = 1; m_dx = 1; m_dy = 1; m_lvl = 0;
            next_tick = n + BD; serve_left = ST;
         end
      end else if (m_phase == 1) begin
         if (n == next_tick) begin
            next_tick = n + BD;
            serve_left--;
            if (serve_left == 0) m_phase = 2;
         end
      end else if (m_phase == 2) begin
         if (n == next_tick) begin
            yb = m_dy ? (y_pos >= YMAX) : (y_pos <= YMIN);
            if (pend_hit) begin
               m_dx = !m_dx; m_lvl = m_lvl < ML ? m_lvl + 1 : ML; m_step = 1;
               if (yb) m_dy = !m_dy;
            end else if (x_pos <= XMIN) begin
               m_sr = 1; m_phase = 3;
            end else if (x_pos >= XMAX) begin
               m_sl = 1; m_phase = 3;
            end else begin
               m_step = 1;
               if (yb) m_dy = !m_dy;
            end
            lock = pend_hit ? 2 : (lock > 0 ? lock - 1 : 0);
            pend_hit = 0;
            next_tick = n + BD - m_lvl * DS;
         end else if (collision_det && lock == 0) pend_hit = 1;
      end else begin
         m_phase = 1; m_load = 1; m_lvl = 0; m_dy = 1; m_dx = was_left;
         pend_hit = 0; lock = 0; next_tick = n + BD; serve_left = ST;
      end
   endtask
   task automatic cyc();
      @(posedge pclk);
      model_edge();
      #1;
      check("cycle", {phase, speed_level, step_en, dir_x, dir_y, load, score_left, score_right},
         {m_phase[1:0], m_lvl[2:0], m_step, m_dx, m_dy, m_load, m_sl, m_sr});
   endtask
   task automatic wait_evt(input int bound, output int k);
      k = 0;
      do begin
         cyc();
         k++;
      end while (!(step_en | score_left | score_right) && k < bound);
      checks++;
      if (!(step_en | score_left | score_right)) begin
         errors++;
         $display("FAIL evt_timeout: no strobe within %0d cycles", bound);
      end
   endtask
   task automatic wait_phase(input logic [1:0] p, input int bound);
      int k;
      k = 0;
      while (phase != p && k < bound) begin
         cyc();
         k++;
      end
      check("phase_reached", phase, p);
   endtask
   initial begin
      int k;
      int r;
      tbl[0] = '{1, 0, 0, 50, 30, 1, 1, 0, 1};
      tbl[1] = '{0, 0, 0, 50, 30, 20, 2, 0, 1};
      tbl[2] = '{0, 0, 0, 50, 30, 10, 2, 0, 1};
      tbl[3] = '{0, 0, 1, 50, 30, 5, 2, 0, 1};
      tbl[4] = '{0, 0, 0, 50, 30, 5, 2, 1, 0};
      tbl[5] = '{0, 0, 1, 50, 30, 8, 2, 1, 0};
      tbl[6] = '{0, 0, 1, 50, 30, 8, 2, 1, 0};
      tbl[7] = '{0, 0, 1, 50, 30, 8, 2, 2, 1};
      tbl[8] = '{0, 1, 0, 50, 30, 1, 0, 2, 1};
      tbl[9] = '{1, 0, 0, 50, 30, 1, 1, 0, 1};
      model_reset();
      repeat (2) @(posedge pclk);
      #1;
      check("reset_outs", {phase, speed_level, step_en, dir_x, dir_y, load, score_left, score_right}, 11'b00000011000);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         start = tbl[i].start; stop = tbl[i].stop; collision_det = tbl[i].col;
         x_pos = 12'(tbl[i].x); y_pos = 12'(tbl[i].y);
         repeat (tbl[i].cycles) cyc();
         check($sformatf("tbl%0d_phase", i), phase, tbl[i].ph);
         check($sformatf("tbl%0d_level", i), speed_level, tbl[i].lvl);
         check($sformatf("tbl%0d_dir_x", i), dir_x, tbl[i].dx);
      end
      start = 0;
      wait_phase(2'd2, 40);
      wait_evt(30, k);
      check("first_step_latency", k, 10);
      check("serve_dirs", {dir_x, dir_y}, 2'b11);
      wait_evt(30, k);
      check("period_l0", k, 10);
      cyc();
      check("step_width", step_en, 0);
      collision_det = 1; cyc(); collision_det = 0;
      wait_evt(30, k);
      check("bounce_dir_x", dir_x, 0);
      check("bounce_level", speed_level, 1);
      wait_evt(30, k);
      check("period_l1", k, 8);
      collision_det = 1; cyc(); collision_det = 0;
      wait_evt(30, k);
      check("lockout_no_flip", {dir_x, speed_level}, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         collision_det = 1; cyc(); collision_det = 0;
         repeat (3) wait_evt(30, k);
      end
      check("level_saturated", speed_level, 3);
      check("dir_x_after_flips", dir_x, 1);
      check("period_l3", k, 4);
      y_pos = 50;
      wait_evt(30, k);
      check("y_bottom_bounce", dir_y, 0);
      y_pos = 10;
      wait_evt(30, k);
      check("y_top_bounce", dir_y, 1);
      y_pos = 30; x_pos = 5;
      wait_evt(30, k);
      check("score_right_tick", {score_right, step_en, phase}, 4'b1011);
      cyc();
      check("scored_to_serve", {phase, load, dir_x, speed_level}, 7'b0110000);
      check("score_pulse_width", score_right, 0);
      x_pos = 50;
      wait_phase(2'd2, 40);
      collision_det = 1; cyc(); collision_det = 0; x_pos = 5;
      wait_evt(30, k);
      check("bounce_beats_score", {score_right, step_en, phase}, 4'b0110);
      x_pos = 120;
      wait_evt(30, k);
      check("score_left_tick", score_left, 1);
      cyc();
      check("serve_toward_left", {phase, dir_x}, 3'b011);
      x_pos = 50;
      wait_phase(2'd2, 40);
      stop = 1; cyc(); stop = 0;
      check("stop_to_idle", {phase, step_en}, 3'b000);
      start = 1; stop = 1; cyc(); start = 0; stop = 0;
      check("stop_beats_start", phase, 0);
      start = 1; cyc(); start = 0;
      repeat (5) cyc();
      #2 reset_n = 0;
      #1;
      check("async_reset_outs", {phase, speed_level, step_en, dir_x, dir_y, load, score_left, score_right}, 11'b00000011000);
      model_reset();
      @(posedge pclk);
      #1 reset_n = 1;
      for (int i = 0; i < 3000; i++) begin
         start = $urandom_range(0, 19) == 0;
         stop = $urandom_range(0, 399) == 0;
         collision_det = $urandom_range(0, 5) == 0;
         r = $urandom_range(0, 29);
         x_pos = r == 0 ? 12'($urandom_range(0, 10)) : r == 1 ? 12'($urandom_range(100, 4095)) : 12'($urandom_range(11, 99));
         r = $urandom_range(0, 9);
         y_pos = r == 0 ? 12'($urandom_range(0, 10)) : r == 1 ? 12'($urandom_range(50, 60)) : 12'($urandom_range(11, 49));
         cyc();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
